// File: rtl/imem_loader.sv
// imem_loader -- byte-serial program loader for the instruction memory.
//
// Accepts a byte stream over a valid/ready handshake, assembles each group of
// four bytes big-endian (first byte -> bits 31:24) into a 32-bit instruction
// word, and issues one single-cycle write per word at word addresses
// 0 .. NUM_WORDS-1. After the last word the loader parks in DONE until the
// next start.
//
// Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//   keeps an 8-bit running XOR of all accepted data bytes, and after the last
//   write waits in CHECK for one extra checksum byte. err reports a mismatch.
//   Without the macro there is no CHECK state and err is tied to 0.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-low reset
//   start       begin a load (honoured only in IDLE or DONE)
//   byte_valid  byte_data carries a byte this cycle
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle
//   wr_en       one-cycle write strobe to the instruction memory
//   wr_addr     word address of the write (held while wr_en=0)
//   wr_data     assembled instruction word (held while wr_en=0)
//   busy        high in every state except IDLE and DONE
//   done        load complete, held until next start or reset
//   err         checksum mismatch flag
module imem_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [31:0]             data_reg, data_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
  logic [31:0]             wr_data_reg, wr_data_next;
  logic [31:0]             shifted;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              csum_reg, csum_next;
  logic                    err_reg, err_next;
`endif

  assign shifted = {data_reg[23:0], byte_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      data_reg    <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg    <= '0;
      err_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg    <= csum_next;
      err_reg     <= err_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_next    = csum_reg;
    err_next     = err_reg;
`endif
    byte_ready   = 1'b0;
    wr_en        = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        busy = 1'b0;
        done = (state_reg == DONE);
        if (start) begin
          state_next = ASSEMBLE;
          addr_next  = '0;
          cnt_next   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next  = '0;
          err_next   = 1'b0;
`endif
        end
      end

      ASSEMBLE: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          data_next = shifted;
          cnt_next  = cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next = csum_reg ^ byte_data;
`endif
          if (cnt_reg == 2'd3) begin
            // Capture the write port registers here so that they change only
            // when a write is issued and otherwise hold their last values.
            state_next   = WRITE;
            wr_addr_next = addr_reg;
            wr_data_next = shifted;
          end
        end
      end

      WRITE: begin
        wr_en = 1'b1;
        if (addr_reg == LAST_ADDR) begin
          // Address is never incremented past the last word, so it cannot wrap.
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else begin
          addr_next  = addr_reg + ADDR_WIDTH'(1);
          cnt_next   = '0;
          state_next = ASSEMBLE;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          err_next   = (byte_data != csum_reg);
          state_next = DONE;
        end
      end
`endif

      default: state_next = IDLE;
    endcase
  end

  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-serial program loader that writes 32-bit MIPS instruction words into the instruction memory's storage array.
- Accepts a byte stream over a valid/ready handshake and assembles bytes big-endian into words.
- Issues one write per word at sequential word addresses starting from 0.
- Sits between the boot/debug byte source and the instruction memory write port; replaces hard-coded reset-time contents with a runtime download.

Parameters:
- ADDR_WIDTH, 4, word-address width; matches the instruction memory index width.
- NUM_WORDS, 16, words per load; legal range 1 .. 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- start  input  1  begin a load; sampled only in IDLE or DONE.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle write strobe to instruction memory.
- wr_addr  output  ADDR_WIDTH  word address for the write.
- wr_data  output  32  assembled instruction word.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  load complete; held until the next start or reset.
- err  output  1  checksum mismatch flag; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE; byte counter, word address and shift register clear to 0.
  - All outputs are 0: byte_ready, wr_en, wr_addr, wr_data, busy, done, err.
  - Reset overrides every other input, including in the middle of a word or a write. A partially assembled word is discarded and never written.
- States: IDLE, ASSEMBLE, WRITE, DONE; CHECK is added by the optional feature.
- IDLE:
  - start=1 -> ASSEMBLE; clears word address to 0, byte count to 0, done to 0, err to 0.
- ASSEMBLE:
  - byte_ready=1.
  - A byte transfers only when byte_valid && byte_ready are both high at a rising edge.
  - Each accepted byte shifts in big-endian: data = {data[23:0], byte_data}. The first byte lands in bits 31:24.
  - byte_valid=0 stalls indefinitely with no state change.
  - On the 4th accepted byte -> WRITE.
- WRITE (exactly 1 cycle):
  - byte_ready=0, wr_en=1, wr_addr = current word address, wr_data = assembled word.
  - If word address == NUM_WORDS-1 -> DONE (or CHECK when the feature is enabled).
  - Otherwise the word address increments, byte count clears, and the state returns to ASSEMBLE.
- Latency and throughput:
  - wr_en rises on the cycle after the edge that accepts the 4th byte.
  - Sustained throughput is 1 word per 5 cycles.
- DONE:
  - done=1, busy=0, byte_ready=0.
  - start=1 -> ASSEMBLE with the same clearing as from IDLE; done drops on that edge.
- Field rules:
  - start is ignored while busy.
  - byte_valid outside ASSEMBLE/CHECK is ignored; no byte is consumed.
  - The word address never wraps mid-load. When NUM_WORDS == 2**ADDR_WIDTH, the last address is all-ones and the load terminates there.
  - wr_addr and wr_data hold their last values when wr_en=0. The memory must qualify writes on wr_en only.
- Simultaneous events:
  - rst=0 together with start or byte_valid: reset wins.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every accepted data byte is kept; it clears at start.
  - After the last WRITE the state goes to CHECK with byte_ready=1 and waits for one more byte.
  - On acceptance: err = (byte_data != running XOR), then -> DONE.
  - err is held with done until the next start or reset.
- Undefined:
  - No CHECK state exists; WRITE of the last word goes directly to DONE.
  - err is tied to 0.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release with no start -> all outputs 0, state IDLE, byte_ready=0.
- Single-word load (NUM_WORDS=1): start, then bytes 8C,01,00,00 sent back-to-back -> wr_en=1 for exactly one cycle, wr_addr=0, wr_data=32'h8C010000, cycle after the 4th byte; then done=1.
- Full default load: 16 words where word k = 32'h00000000+k, byte_valid toggled randomly -> 16 single-cycle strobes at addresses 0..15 in order, correct data each time, no wr_en after address 15, done=1, busy=0.
- Reset mid-word: after 2 bytes of word 3, drive rst=0 for one cycle -> no write for address 3, outputs all 0; a new start reloads from address 0.
- Ignored inputs: pulse start during ASSEMBLE and byte_valid=1 during WRITE and DONE -> no restart, no extra byte consumed, address sequence unaffected.
- Checksum (IMEM_LOADER_CHECKSUM_EN, NUM_WORDS=1): bytes 12,34,56,78, then checksum 08 -> done=1, err=0; repeat with checksum 09 -> err=1.
